// File: rtl/tlb_manager_if.sv
// rtl/tlb_manager_if.sv - TLB manager request/response bundle
interface tlb_manager_if;
    logic        op_valid;
    logic [1:0]  op_code;
    logic        op_ready;
    logic [3:0]  index_in;
    logic [79:0] entry_in;
    logic [3:0]  wired;
    logic        done;
    logic [79:0] rd_entry;
    logic [3:0]  probe_index;
    logic        probe_miss;
    logic [3:0]  random;
    logic [79:0] tlb_entry0,  tlb_entry1,  tlb_entry2,  tlb_entry3;
    logic [79:0] tlb_entry4,  tlb_entry5,  tlb_entry6,  tlb_entry7;
    logic [79:0] tlb_entry8,  tlb_entry9,  tlb_entry10, tlb_entry11;
    logic [79:0] tlb_entry12, tlb_entry13, tlb_entry14, tlb_entry15;

    modport master (
        output op_valid, op_code, index_in, entry_in, wired,
        input  op_ready, done, rd_entry, probe_index, probe_miss, random,
        input  tlb_entry0, tlb_entry1, tlb_entry2, tlb_entry3,
        input  tlb_entry4, tlb_entry5, tlb_entry6, tlb_entry7,
        input  tlb_entry8, tlb_entry9, tlb_entry10, tlb_entry11,
        input  tlb_entry12, tlb_entry13, tlb_entry14, tlb_entry15
    );

    modport slave (
        input  op_valid, op_code, index_in, entry_in, wired,
        output op_ready, done, rd_entry, probe_index, probe_miss, random,
        output tlb_entry0, tlb_entry1, tlb_entry2, tlb_entry3,
        output tlb_entry4, tlb_entry5, tlb_entry6, tlb_entry7,
        output tlb_entry8, tlb_entry9, tlb_entry10, tlb_entry11,
        output tlb_entry12, tlb_entry13, tlb_entry14, tlb_entry15
    );
endinterface

// File: rtl/tlb_manager.sv
// rtl/tlb_manager.sv - 16-entry TLB store with TLBWI/TLBWR/TLBR and sequential TLBP scan
module tlb_manager (
    input  logic          clk,
    input  logic          rst_n,
    tlb_manager_if.slave  bus
);
    typedef enum logic {S_IDLE, S_PROBE} state_t;

    localparam logic [1:0] OP_TLBWI = 2'b00;
    localparam logic [1:0] OP_TLBWR = 2'b01;
    localparam logic [1:0] OP_TLBR  = 2'b10;
    localparam logic [1:0] OP_TLBP  = 2'b11;

    state_t      state_q;
    logic [79:0] entry_q [16];
    logic [79:0] rd_entry_q;
    logic [3:0]  probe_index_q;
    logic        probe_miss_q;
    logic        done_q;
    logic [3:0]  random_q;
    logic [3:0]  random_d;
    logic [18:0] vpn2_q;
    logic [7:0]  asid_q;
    logic [3:0]  scan_q;
    logic        cmp_valid_q;
    logic        cmp_hit_q;
    logic [3:0]  cmp_idx_q;
    logic        scan_hit;

    always_comb begin
        random_d = (random_q <= bus.wired) ? 4'd15 : random_q - 4'd1;
    end

    // Valid bits are deliberately not part of the probe match.
    always_comb begin
        scan_hit = (entry_q[scan_q][70:52] == vpn2_q) &&
                   (entry_q[scan_q][71] || (entry_q[scan_q][79:72] == asid_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            for (int i = 0; i < 16; i++) entry_q[i] <= '0;
            rd_entry_q    <= '0;
            probe_index_q <= '0;
            probe_miss_q  <= 1'b0;
            done_q        <= 1'b0;
            random_q      <= 4'd15;
            vpn2_q        <= '0;
            asid_q        <= '0;
            scan_q        <= '0;
            cmp_valid_q   <= 1'b0;
            cmp_hit_q     <= 1'b0;
            cmp_idx_q     <= '0;
        end else begin
            random_q <= random_d;
            done_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.op_valid) begin
                        case (bus.op_code)
                            OP_TLBWI: begin
                                entry_q[bus.index_in] <= bus.entry_in;
                                done_q                <= 1'b1;
                            end
                            // random_q here is the pre-decrement value.
                            OP_TLBWR: begin
                                entry_q[random_q] <= bus.entry_in;
                                done_q            <= 1'b1;
                            end
                            OP_TLBR: begin
                                rd_entry_q <= entry_q[bus.index_in];
                                done_q     <= 1'b1;
                            end
                            default: begin
                                vpn2_q      <= bus.entry_in[70:52];
                                asid_q      <= bus.entry_in[79:72];
                                scan_q      <= '0;
                                cmp_valid_q <= 1'b0;
                                state_q     <= S_PROBE;
                            end
                        endcase
                    end
                end
                S_PROBE: begin
                    // Compare result is registered, so the decision lags the scan by one cycle.
                    if (cmp_valid_q && cmp_hit_q) begin
                        probe_index_q <= cmp_idx_q;
                        probe_miss_q  <= 1'b0;
                        done_q        <= 1'b1;
                        state_q       <= S_IDLE;
                    end else if (cmp_valid_q && (cmp_idx_q == 4'd15)) begin
                        probe_index_q <= '0;
                        probe_miss_q  <= 1'b1;
                        done_q        <= 1'b1;
                        state_q       <= S_IDLE;
                    end else begin
                        cmp_valid_q <= 1'b1;
                        cmp_hit_q   <= scan_hit;
                        cmp_idx_q   <= scan_q;
                        scan_q      <= scan_q + 4'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.op_ready    = (state_q == S_IDLE);
    assign bus.done        = done_q;
    assign bus.rd_entry    = rd_entry_q;
    assign bus.probe_index = probe_index_q;
    assign bus.probe_miss  = probe_miss_q;
    assign bus.random      = random_q;
    assign bus.tlb_entry0  = entry_q[0];
    assign bus.tlb_entry1  = entry_q[1];
    assign bus.tlb_entry2  = entry_q[2];
    assign bus.tlb_entry3  = entry_q[3];
    assign bus.tlb_entry4  = entry_q[4];
    assign bus.tlb_entry5  = entry_q[5];
    assign bus.tlb_entry6  = entry_q[6];
    assign bus.tlb_entry7  = entry_q[7];
    assign bus.tlb_entry8  = entry_q[8];
    assign bus.tlb_entry9  = entry_q[9];
    assign bus.tlb_entry10 = entry_q[10];
    assign bus.tlb_entry11 = entry_q[11];
    assign bus.tlb_entry12 = entry_q[12];
    assign bus.tlb_entry13 = entry_q[13];
    assign bus.tlb_entry14 = entry_q[14];
    assign bus.tlb_entry15 = entry_q[15];
endmodule

// File: tb/tb_tlb_manager.sv
// tb/tb_tlb_manager.sv - scoreboard bench for tlb_manager
module tb_tlb_manager;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tlb_manager_if tif();
    tlb_manager dut (.clk(clk), .rst_n(rst_n), .bus(tif));

    logic [79:0] ent [16];
    assign ent[0]  = tif.tlb_entry0;
    assign ent[1]  = tif.tlb_entry1;
    assign ent[2]  = tif.tlb_entry2;
    assign ent[3]  = tif.tlb_entry3;
    assign ent[4]  = tif.tlb_entry4;
    assign ent[5]  = tif.tlb_entry5;
    assign ent[6]  = tif.tlb_entry6;
    assign ent[7]  = tif.tlb_entry7;
    assign ent[8]  = tif.tlb_entry8;
    assign ent[9]  = tif.tlb_entry9;
    assign ent[10] = tif.tlb_entry10;
    assign ent[11] = tif.tlb_entry11;
    assign ent[12] = tif.tlb_entry12;
    assign ent[13] = tif.tlb_entry13;
    assign ent[14] = tif.tlb_entry14;
    assign ent[15] = tif.tlb_entry15;

    typedef struct {
        int          kind;
        logic [79:0] entry;
        logic [3:0]  idx;
        logic        miss;
        int          cyc;
    } exp_t;

    exp_t        sbq [$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [3:0]  rm;
    logic [79:0] m [16];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rm <= 4'd15;
        else        rm <= (rm <= tif.wired) ? 4'd15 : rm - 4'd1;
    end

    always @(negedge clk) begin
        exp_t e;
        if (tif.done === 1'b1) begin
            total++;
            assert (sbq.size() != 0) else begin
                bad++; $error("FAIL spurious_done cyc=%0d queued=%0d required>0", cyc, sbq.size());
            end
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                total++;
                assert (cyc === e.cyc) else begin
                    bad++; $error("FAIL done_cycle got=%0d exp=%0d", cyc, e.cyc);
                end
                case (e.kind)
                    0: begin
                        total++;
                        assert (ent[e.idx] === e.entry) else begin
                            bad++; $error("FAIL write_entry%0d got=%h exp=%h", e.idx, ent[e.idx], e.entry);
                        end
                    end
                    1: begin
                        total++;
                        assert (tif.rd_entry === e.entry) else begin
                            bad++; $error("FAIL rd_entry got=%h exp=%h", tif.rd_entry, e.entry);
                        end
                    end
                    default: begin
                        total++;
                        assert (tif.probe_index === e.idx) else begin
                            bad++; $error("FAIL probe_index got=%0d exp=%0d", tif.probe_index, e.idx);
                        end
                        total++;
                        assert (tif.probe_miss === e.miss) else begin
                            bad++; $error("FAIL probe_miss got=%b exp=%b", tif.probe_miss, e.miss);
                        end
                    end
                endcase
            end
        end
    end

    function automatic logic [79:0] mk(input logic [7:0] a, input logic g, input logic [18:0] v,
                                       input logic [51:0] lo);
        return {a, g, v, lo};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        total++;
        assert (got === exp) else begin
            bad++; $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic accept(input logic [1:0] code, input logic [3:0] idx, input logic [79:0] e,
                          output int t, output logic [3:0] r);
        int n = 0;
        while (tif.op_ready !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk("ready_before_accept", 80'(tif.op_ready), 80'(1'b1));
        tif.op_valid = 1'b1;
        tif.op_code  = code;
        tif.index_in = idx;
        tif.entry_in = e;
        r = rm;
        step();
        t = cyc;
        tif.op_valid = 1'b0;
    endtask

    task automatic do_write(input logic [3:0] idx, input logic [79:0] e);
        int t;
        logic [3:0] r;
        accept(2'b00, idx, e, t, r);
        m[idx] = e;
        sbq.push_back('{0, e, idx, 1'b0, t});
    endtask

    task automatic do_wr(input logic [79:0] e);
        int t;
        logic [3:0] r;
        accept(2'b01, 4'd0, e, t, r);
        m[r] = e;
        sbq.push_back('{0, e, r, 1'b0, t});
    endtask

    task automatic do_read(input logic [3:0] idx);
        int t;
        logic [3:0] r;
        accept(2'b10, idx, '0, t, r);
        sbq.push_back('{1, m[idx], idx, 1'b0, t});
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 40) begin
            step();
            n++;
        end
        chk("scoreboard_drained", 80'(sbq.size()), 80'(0));
    endtask

    task automatic do_probe(input logic [18:0] vpn, input logic [7:0] asid);
        int t;
        int k;
        int lat;
        logic hit;
        logic [3:0] r;
        logic [95:0] junk;
        accept(2'b11, 4'd0, mk(asid, 1'b0, vpn, 52'h0), t, r);
        junk = {$urandom(), $urandom(), $urandom()};
        tif.entry_in = junk[79:0];
        hit = 1'b0;
        k = 0;
        for (int i = 0; i < 16; i++) begin
            if (!hit && m[i][70:52] == vpn && (m[i][71] || m[i][79:72] == asid)) begin
                hit = 1'b1;
                k = i;
            end
        end
        lat = hit ? 2 + k : 17;
        sbq.push_back('{2, '0, hit ? 4'(k) : 4'd0, !hit, t + lat});
        for (int j = 1; j < lat; j++) begin
            step();
            chk("ready_low_in_probe", 80'(tif.op_ready), 80'(1'b0));
        end
        drain();
    endtask

    logic [79:0] e1, e7;
    int          tr;
    logic [3:0]  rr;

    initial begin
        tif.op_valid = 1'b0;
        tif.op_code  = 2'b00;
        tif.index_in = 4'd0;
        tif.entry_in = '0;
        tif.wired    = 4'd3;
        for (int i = 0; i < 16; i++) m[i] = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_op_ready", 80'(tif.op_ready), 80'(1'b1));
        chk("rst_done", 80'(tif.done), 80'(1'b0));
        chk("rst_rd_entry", tif.rd_entry, 80'h0);
        chk("rst_probe_index", 80'(tif.probe_index), 80'(4'd0));
        chk("rst_probe_miss", 80'(tif.probe_miss), 80'(1'b0));
        chk("rst_random", 80'(tif.random), 80'(4'd15));
        chk("rst_entry0", ent[0], 80'h0);
        chk("rst_entry15", ent[15], 80'h0);

        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("random_seq", 80'(tif.random), 80'((i < 13) ? 15 - i : 15 - (i - 13)));
            step();
        end

        e7 = mk(8'h07, 1'b0, 19'h7_0707, 52'hF_7777_0000_7777);
        begin
            int n = 0;
            while (rm != 4'd7 && n < 40) begin
                step();
                n++;
            end
        end
        do_wr(e7);
        drain();
        chk("tlbwr_at_random7", ent[7], e7);

        e1 = mk(8'h12, 1'b0, 19'h0AAAA, 52'hC_0FFE_E123_4567);
        do_write(4'd5, e1);
        do_read(4'd5);
        do_read(4'd7);
        drain();
        chk("rd_entry_holds", tif.rd_entry, e7);

        do_write(4'd9, mk(8'h33, 1'b1, 19'h4_1234, 52'h1_1111_2222_3333));
        drain();
        do_probe(19'h4_1234, 8'h44);
        do_read(4'd5);
        drain();
        chk("probe_index_kept", 80'(tif.probe_index), 80'(4'd9));
        chk("probe_miss_kept", 80'(tif.probe_miss), 80'(1'b0));

        do_write(4'd12, mk(8'h55, 1'b0, 19'h2_2222, 52'h0));
        drain();
        do_probe(19'h2_2222, 8'h56);

        do_write(4'd2, mk(8'h77, 1'b0, 19'h5_5555, 52'hA));
        do_write(4'd11, mk(8'h77, 1'b0, 19'h5_5555, 52'hB));
        drain();
        do_probe(19'h5_5555, 8'h77);

        accept(2'b11, 4'd0, mk(8'h01, 1'b0, 19'h6_0606, 52'h0), tr, rr);
        repeat (6) step();
        rst_n = 1'b0;
        repeat (2) step();
        for (int i = 0; i < 16; i++) chk("abort_entry_cleared", ent[i], 80'h0);
        chk("abort_rd_entry", tif.rd_entry, 80'h0);
        chk("abort_probe_index", 80'(tif.probe_index), 80'(4'd0));
        chk("abort_probe_miss", 80'(tif.probe_miss), 80'(1'b0));
        chk("abort_random", 80'(tif.random), 80'(4'd15));
        chk("abort_op_ready", 80'(tif.op_ready), 80'(1'b1));
        chk("abort_done", 80'(tif.done), 80'(1'b0));
        for (int i = 0; i < 16; i++) m[i] = '0;
        rst_n = 1'b1;
        repeat (20) step();

        do_write(4'd6, mk(8'h21, 1'b0, 19'h3_0303, 52'h5));
        drain();
        do_probe(19'h3_0303, 8'h21);

        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
